// File: rtl/snow64_long_div_u16_by_u8_seq_if.sv
// Handshake bundle for the u16/u8 divide request sequencer: request port,
// divider command/result port and response port.
// master: the surrounding logic (issue, divider, writeback).
// slave: the sequencer itself.
interface snow64_long_div_u16_by_u8_seq_if #(
    parameter int unsigned TAG_WIDTH = 4
);
    // request side (from ALU issue)
    logic                 in_req_valid;
    logic                 in_req_ready;
    logic [15:0]          in_req_a;
    logic [7:0]           in_req_b;
    logic [TAG_WIDTH-1:0] in_req_tag;

    // divider command / result side
    logic                 div_start;
    logic [15:0]          div_a;
    logic [7:0]           div_b;
    logic                 div_can_accept_cmd;
    logic                 div_data_valid;
    logic [15:0]          div_data;

    // response side (to ALU writeback)
    logic                 out_rsp_valid;
    logic                 out_rsp_ready;
    logic [15:0]          out_rsp_quot;
    logic [7:0]           out_rsp_rem;
    logic                 out_rsp_div_by_zero;
    logic [TAG_WIDTH-1:0] out_rsp_tag;

    modport master (
        output in_req_valid, in_req_a, in_req_b, in_req_tag,
        input  in_req_ready,
        input  div_start, div_a, div_b,
        output div_can_accept_cmd, div_data_valid, div_data,
        input  out_rsp_valid, out_rsp_quot, out_rsp_rem, out_rsp_div_by_zero, out_rsp_tag,
        output out_rsp_ready
    );

    modport slave (
        input  in_req_valid, in_req_a, in_req_b, in_req_tag,
        output in_req_ready,
        output div_start, div_a, div_b,
        input  div_can_accept_cmd, div_data_valid, div_data,
        output out_rsp_valid, out_rsp_quot, out_rsp_rem, out_rsp_div_by_zero, out_rsp_tag,
        input  out_rsp_ready
    );
endinterface

// File: rtl/snow64_long_div_u16_by_u8_seq.sv
// Request sequencer for the radix-8 u16/u8 long divider.
// Queues divide requests in a small FIFO, issues one at a time to the
// divider, derives the remainder from the returned quotient, flags
// divide-by-zero without touching the divider, and returns tagged
// results in request order over a valid/ready port.
module snow64_long_div_u16_by_u8_seq #(
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    snow64_long_div_u16_by_u8_seq_if.slave  bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [15:0]          a;
        logic [7:0]           b;
        logic [TAG_WIDTH-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RSP
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    req_t                 fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic                 req_ready;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    req_t                 head;
    req_t                 wr_entry;

    // ------------------------------------------------------------------
    // Sequencer state, operand and response registers
    // ------------------------------------------------------------------
    state_t               state;
    logic [15:0]          op_a;
    logic [7:0]           op_b;
    logic [TAG_WIDTH-1:0] op_tag;

    logic                 rsp_valid;
    logic [15:0]          rsp_quot;
    logic [7:0]           rsp_rem;
    logic                 rsp_dbz;
    logic [TAG_WIDTH-1:0] rsp_tag;

    logic [15:0]          rem_prod;
    logic [15:0]          rem_diff;

    assign fifo_empty = (count == '0);
    assign push       = bus.in_req_valid && req_ready;
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];

    assign wr_entry.a   = bus.in_req_a;
    assign wr_entry.b   = bus.in_req_b;
    assign wr_entry.tag = bus.in_req_tag;

    // Next occupancy; ready is registered from it so it always equals !full.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_next;
            req_ready <= (count_next != CNT_W'(FIFO_DEPTH));
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wr_entry;
        end
    end

    // Remainder from the divider quotient; a 16-bit truncated product is
    // enough because the true remainder is always below the divisor.
    always_comb begin
        rem_prod = 16'(bus.div_data * {8'h00, op_b});
        rem_diff = op_a - rem_prod;
    end

    // Sequencer FSM: pop, issue, wait for the divider, hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            op_tag    <= '0;
            rsp_valid <= 1'b0;
            rsp_quot  <= '0;
            rsp_rem   <= '0;
            rsp_dbz   <= 1'b0;
            rsp_tag   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        op_a   <= head.a;
                        op_b   <= head.b;
                        op_tag <= head.tag;
                        if (head.b == '0) begin
                            rsp_quot  <= '0;
                            rsp_rem   <= '0;
                            rsp_dbz   <= 1'b1;
                            rsp_tag   <= head.tag;
                            rsp_valid <= 1'b1;
                            state     <= S_RSP;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // Also absorbs a divider still finishing a job orphaned by reset.
                    if (bus.div_can_accept_cmd) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.div_data_valid) begin
                        rsp_quot  <= bus.div_data;
                        rsp_rem   <= rem_diff[7:0];
                        rsp_dbz   <= 1'b0;
                        rsp_tag   <= op_tag;
                        rsp_valid <= 1'b1;
                        state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (bus.out_rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_req_ready        = req_ready;
    assign bus.div_start           = (state == S_ISSUE) && bus.div_can_accept_cmd;
    assign bus.div_a               = op_a;
    assign bus.div_b               = op_b;
    assign bus.out_rsp_valid       = rsp_valid;
    assign bus.out_rsp_quot        = rsp_quot;
    assign bus.out_rsp_rem         = rsp_rem;
    assign bus.out_rsp_div_by_zero = rsp_dbz;
    assign bus.out_rsp_tag         = rsp_tag;

endmodule
